// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer RAM arbiter: a 4-word display prefetch FIFO competes
// with a draw port. The display is urgent below 2 words, and a vsync rising edge restarts the frame.
module fb_access_arbiter #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FRAME_WORDS = 30000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              disp_pop,
  output logic [DATA_W-1:0] disp_word,
  output logic              disp_empty,
  output logic              disp_underrun,
  input  logic              drw_req,
  input  logic              drw_we,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [DATA_W-1:0] drw_wdata,
  output logic              drw_gnt,
  output logic              drw_rvalid,
  output logic [DATA_W-1:0] drw_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned URGENT = 2;

  typedef enum logic [1:0] {WAIT_FRAME, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic              vs_q1, vs_q2, vs_rise;
  logic [DATA_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q, occ;
  logic              inflight_q;
  logic [ADDR_W-1:0] disp_addr_q, last_addr_q;
  logic [DATA_W-1:0] last_wdata_q;
  logic              rvalid_q, underrun_q;
  logic              issue_disp, issue_drw, push, pop;

  assign vs_rise = vs_q1 & ~vs_q2;
  // Occupancy counts reads still in flight so the FIFO can never overflow.
  assign occ     = cnt_q + CNT_W'(inflight_q);
  assign push    = inflight_q & (state_q != FLUSH);
  assign pop     = disp_pop & (cnt_q != '0) & (state_q != FLUSH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_FRAME;
    else          state_q <= state_d;
  end

  // Next state and single-access arbitration; nothing issues while in reset.
  always_comb begin
    state_d    = state_q;
    issue_disp = 1'b0;
    issue_drw  = 1'b0;
    unique case (state_q)
      WAIT_FRAME: begin
        issue_drw = drw_req;
        if (vs_rise) state_d = FLUSH;
      end
      RUN: begin
        if (occ < CNT_W'(URGENT))     issue_disp = 1'b1;
        else if (drw_req)             issue_drw  = 1'b1;
        else if (occ < CNT_W'(DEPTH)) issue_disp = 1'b1;
        if (vs_rise) state_d = FLUSH;
      end
      FLUSH: begin
        issue_drw = drw_req;
        state_d   = RUN;
      end
      default: state_d = WAIT_FRAME;
    endcase
    if (!reset_n) begin
      issue_disp = 1'b0;
      issue_drw  = 1'b0;
    end
  end

  assign drw_gnt       = issue_drw;
  assign mem_we        = issue_drw & drw_we;
  assign mem_addr      = issue_drw ? drw_addr : (issue_disp ? disp_addr_q : last_addr_q);
  assign mem_wdata     = mem_we ? drw_wdata : last_wdata_q;
  assign drw_rvalid    = rvalid_q;
  assign drw_rdata     = rvalid_q ? mem_rdata : '0;
  assign disp_empty    = (cnt_q == '0);
  assign disp_word     = disp_empty ? '0 : fifo_q[rd_ptr_q];
  assign disp_underrun = underrun_q;

  // Prefetch FIFO; a read returning during FLUSH is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else if (state_q == FLUSH) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue_disp;
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                disp_addr_q <= '0;
    else if (state_q == FLUSH)   disp_addr_q <= '0;
    else if (issue_disp)
      disp_addr_q <= (disp_addr_q == ADDR_W'(FRAME_WORDS - 1)) ? '0 : disp_addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q1        <= 1'b0;
      vs_q2        <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      rvalid_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      vs_q1        <= vsync;
      vs_q2        <= vs_q1;
      last_addr_q  <= mem_addr;
      last_wdata_q <= mem_wdata;
      rvalid_q     <= issue_drw & ~drw_we;
      if ((state_q == RUN) && disp_pop && (cnt_q == '0)) underrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural RAM and a draw-read scoreboard.
module tb_fb_access_arbiter;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAME  = 30000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              vsync, disp_pop;
  logic [DATA_W-1:0] disp_word;
  logic              disp_empty, disp_underrun;
  logic              drw_req, drw_we;
  logic [ADDR_W-1:0] drw_addr;
  logic [DATA_W-1:0] drw_wdata;
  logic              drw_gnt, drw_rvalid;
  logic [DATA_W-1:0] drw_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  fb_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(FRAME)) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .disp_pop(disp_pop),
    .disp_word(disp_word), .disp_empty(disp_empty), .disp_underrun(disp_underrun),
    .drw_req(drw_req), .drw_we(drw_we), .drw_addr(drw_addr), .drw_wdata(drw_wdata),
    .drw_gnt(drw_gnt), .drw_rvalid(drw_rvalid), .drw_rdata(drw_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: unwritten words hold a unique address-derived pattern.
  bit                wr_valid [32768];
  logic [DATA_W-1:0] wr_data  [32768];
  always @(posedge clk) begin
    if (mem_we) begin
      wr_valid[mem_addr] <= 1'b1;
      wr_data[mem_addr]  <= mem_wdata;
    end
    mem_rdata <= wr_valid[mem_addr] ? wr_data[mem_addr] : (16'(mem_addr) ^ 16'hC3A5);
  end

  int                total = 0;
  int                bad   = 0;
  logic [DATA_W-1:0] ref_wr [int];
  logic [DATA_W-1:0] rd_q [$];
  int                exp_k, popped, cycles;
  bit                saw_top, wrap_checked;

  function automatic logic [DATA_W-1:0] exp_word(int a);
    if (ref_wr.exists(a)) return ref_wr[a];
    return 16'(a) ^ 16'hC3A5;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; any draw read data returning is checked against the scoreboard.
  task automatic tick();
    logic [DATA_W-1:0] e;
    @(posedge clk); #1;
    if (drw_rvalid === 1'b1) begin
      if (rd_q.size() == 0) chk("rvalid_unexpected", 32'(drw_rvalid), 0);
      else begin
        e = rd_q.pop_front();
        chk("drw_rdata", drw_rdata, e);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b0; disp_pop = 1'b0;
    drw_req = 1'b1; drw_we = 1'b0; drw_addr = '0; drw_wdata = '0;
    repeat (3) tick();
    chk("rst_gnt", drw_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_empty", disp_empty, 1);
    chk("rst_word", disp_word, 0);
    chk("rst_underrun", disp_underrun, 0);
    chk("rst_rvalid", drw_rvalid, 0);
    chk("rst_rdata", drw_rdata, 0);

    // Draw write granted immediately in WAIT_FRAME
    reset_n = 1'b1; drw_we = 1'b1; drw_addr = 15'd5; drw_wdata = 16'hA5A5; #1;
    chk("wr_gnt", drw_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 5);
    chk("wr_mem_wdata", mem_wdata, 16'hA5A5);
    ref_wr[5] = 16'hA5A5;
    tick();
    drw_req = 1'b0; drw_we = 1'b0;
    repeat (3) begin
      #1;
      chk("wait_hold_addr", mem_addr, 5);
      chk("wait_mem_we", mem_we, 0);
      chk("wait_empty", disp_empty, 1);
      tick();
    end

    // First vsync: FLUSH, then prefetch 0..3
    vsync = 1'b1; #1;
    chk("vs_c0_addr", mem_addr, 5);
    tick(); #1; chk("vs_edge_addr", mem_addr, 5);
    tick(); #1; chk("flush_addr", mem_addr, 5); chk("flush_empty", disp_empty, 1);
    tick(); #1; chk("pf_addr0", mem_addr, 0); chk("pf_empty0", disp_empty, 1);
    tick(); #1; chk("pf_addr1", mem_addr, 1); chk("pf_empty1", disp_empty, 1);
    tick(); vsync = 1'b0; #1;
    chk("pf_addr2", mem_addr, 2); chk("pf_empty2", disp_empty, 0);
    chk("pf_head", disp_word, exp_word(0));
    tick(); #1; chk("pf_addr3", mem_addr, 3);
    repeat (3) begin
      tick(); #1;
      chk("full_hold_addr", mem_addr, 3);
      chk("full_mem_we", mem_we, 0);
    end

    // Draw read while FIFO full
    drw_req = 1'b1; drw_we = 1'b0; drw_addr = 15'd100; #1;
    chk("rd100_gnt", drw_gnt, 1);
    chk("rd100_addr", mem_addr, 100);
    chk("rd100_we", mem_we, 0);
    rd_q.push_back(exp_word(100));
    tick();
    drw_req = 1'b0;
    chk("rd100_rvalid", drw_rvalid, 1);
    disp_pop = 1'b1; #1;
    chk("pop0_word", disp_word, exp_word(0));
    chk("pop0_gnt", drw_gnt, 0);
    chk("pop0_hold_addr", mem_addr, 100);
    exp_k = 1;
    tick();
    disp_pop = 1'b0; drw_req = 1'b1; drw_addr = 15'd200; #1;
    chk("rd200_gnt", drw_gnt, 1);
    chk("rd200_addr", mem_addr, 200);
    rd_q.push_back(exp_word(200));
    tick();
    drw_req = 1'b0; #1;
    chk("disp4_gnt", drw_gnt, 0);
    chk("disp4_addr", mem_addr, 4);
    repeat (2) tick();

    // Draw hogs while popping until the display turns urgent
    for (int i = 0; i < 3; i++) begin
      drw_req = 1'b1; drw_addr = 15'(300 + i); disp_pop = 1'b1; #1;
      chk("hog_pop_word", disp_word, exp_word(exp_k));
      exp_k++;
      chk("hog_gnt", drw_gnt, 1);
      chk("hog_addr", mem_addr, 300 + i);
      rd_q.push_back(exp_word(300 + i));
      tick();
    end
    disp_pop = 1'b0; drw_addr = 15'd303; #1;
    chk("urgent_gnt", drw_gnt, 0);
    chk("urgent_addr", mem_addr, 5);
    tick(); #1;
    chk("late_gnt", drw_gnt, 1);
    chk("late_addr", mem_addr, 303);
    rd_q.push_back(exp_word(303));
    tick();
    drw_req = 1'b0;
    repeat (4) tick();

    // Mid-frame vsync with a display read in flight, then underrun
    disp_pop = 1'b1; vsync = 1'b1; #1;
    chk("mid_pop_word", disp_word, exp_word(exp_k));
    tick(); disp_pop = 1'b0; #1;
    chk("inflight_addr", mem_addr, 8);
    tick(); disp_pop = 1'b1; #1;
    tick(); #1;
    chk("flush_pop_no_underrun", disp_underrun, 0);
    chk("restart_empty", disp_empty, 1);
    chk("restart_addr0", mem_addr, 0);
    tick(); disp_pop = 1'b0; #1;
    chk("underrun_set", disp_underrun, 1);
    chk("underrun_empty", disp_empty, 1);
    chk("restart_addr1", mem_addr, 1);
    tick(); vsync = 1'b0; #1;
    chk("restart_empty_n", disp_empty, 0);
    chk("restart_head", disp_word, exp_word(0));
    exp_k = 0;

    // Stream a full frame plus a few words across the address wrap
    popped = 0; cycles = 0; saw_top = 0; wrap_checked = 0;
    while (popped < int'(FRAME) + 8 && cycles < 40000) begin
      if (disp_empty === 1'b0) begin
        chk("stream_word", disp_word, exp_word(exp_k % int'(FRAME)));
        exp_k++; popped++;
        disp_pop = 1'b1;
      end else disp_pop = 1'b0;
      #1;
      if (saw_top && !wrap_checked && mem_addr !== 15'(FRAME - 1)) begin
        chk("wrap_addr", mem_addr, 0);
        wrap_checked = 1;
      end
      if (mem_addr === 15'(FRAME - 1) && mem_we === 1'b0) saw_top = 1;
      tick();
      cycles++;
    end
    disp_pop = 1'b0;
    chk("stream_count", popped, FRAME + 8);
    chk("wrap_seen", 32'(wrap_checked), 1);

    // Underrun survives a later vsync
    vsync = 1'b1; repeat (2) tick();
    vsync = 1'b0; repeat (4) tick(); #1;
    chk("underrun_sticky", disp_underrun, 1);

    // Reset in the middle of a granted draw read abandons it
    drw_req = 1'b1; drw_we = 1'b0; drw_addr = 15'd50; #1;
    chk("abort_gnt", drw_gnt, 1);
    #2 reset_n = 1'b0; #1;
    chk("abort_gnt_rst", drw_gnt, 0);
    tick(); drw_req = 1'b0; #1;
    chk("abort_rvalid", drw_rvalid, 0);
    chk("abort_underrun_clr", disp_underrun, 0);
    chk("abort_empty", disp_empty, 1);
    chk("abort_mem_addr", mem_addr, 0);
    reset_n = 1'b1;
    tick(); #1;
    chk("abort_rvalid_after", drw_rvalid, 0);
    tick();
    chk("rd_queue_drained", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
FB_ACCESS_ARBITER -- requirements
Module: fb_access_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 15, framebuffer word address width; DATA_W, 16, word width (16 pixels of 1 bpp); FRAME_WORDS, 30000, words per 800x600 frame.
REQ-002 Ports SHALL be: clk  in  1  clock (50 MHz); reset_n  in  1  reset.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be: vsync  in  1  vertical sync from the VGA signal generator; disp_pop  in  1  display consumes head word; disp_word  out  DATA_W  FIFO head word; disp_empty  out  1  FIFO empty; disp_underrun  out  1  sticky underrun flag.
REQ-005 Ports SHALL be: drw_req  in  1  draw request; drw_we  in  1  1=write, 0=read; drw_addr  in  ADDR_W  draw address; drw_wdata  in  DATA_W  write data; drw_gnt  out  1  request issued this cycle; drw_rvalid  out  1  read data valid; drw_rdata  out  DATA_W  read data.
REQ-006 Ports SHALL be: mem_addr  out  ADDR_W  RAM address; mem_we  out  1  RAM write enable; mem_wdata  out  DATA_W  RAM write data; mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read issue.

Function
REQ-007 Exactly one RAM access (display read, draw read or draw write) SHALL be issued per cycle at most.
REQ-008 The display prefetch FIFO SHALL hold 4 words; occupancy SHALL be counted as stored words plus display reads in flight (0..4).
REQ-009 The FSM SHALL have states WAIT_FRAME, RUN, FLUSH; reset enters WAIT_FRAME.
REQ-010 vsync rising edge (registered 0->1) SHALL move WAIT_FRAME or RUN to FLUSH; FLUSH SHALL last exactly 1 cycle and then go to RUN.
REQ-011 In FLUSH, the FIFO SHALL be emptied, any in-flight display read SHALL be discarded on return, display address SHALL reset to 0, disp_underrun SHALL NOT change.
REQ-012 In WAIT_FRAME, no display reads SHALL be issued; draw requests SHALL be granted every cycle drw_req=1.
REQ-013 In RUN, priority SHALL be: display read if occupancy<2 (urgent); else draw if drw_req=1; else display read if occupancy<4; else idle.
REQ-014 Display reads SHALL use a word address counter incremented per issue, wrapping FRAME_WORDS-1 -> 0.
REQ-015 drw_gnt SHALL be combinational on the current cycle's arbitration result; requester holds drw_req/drw_addr/drw_we/drw_wdata stable until drw_gnt=1.
REQ-016 For a granted draw read, drw_rvalid SHALL be 1 for one cycle, exactly one cycle after drw_gnt, with drw_rdata=mem_rdata; writes SHALL NOT produce drw_rvalid.
REQ-017 Display read data SHALL enter the FIFO one cycle after issue; disp_word SHALL show the head word, 0 when empty.
REQ-018 disp_pop with FIFO non-empty SHALL remove the head; same-cycle pop and return SHALL keep occupancy unchanged minus pop plus return consistently.
REQ-019 disp_pop while disp_empty=1 in RUN SHALL set disp_underrun=1 (sticky until reset) and SHALL not change FIFO state.
REQ-020 Draw starvation is accepted: draw waits at most 2 consecutive cycles while display is urgent, never more (FIFO refills at 1 word/cycle, consumption is 1 word/16 cycles).
REQ-021 When idle, mem_we SHALL be 0 and mem_addr SHALL hold its last value.

Reset
REQ-022 While reset_n=0: state WAIT_FRAME, FIFO empty, occupancy 0, display address 0, disp_word=0, disp_empty=1, disp_underrun=0, drw_gnt=0, drw_rvalid=0, drw_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-023 Reset asserted mid-access SHALL abandon the access; returned RAM data after release SHALL be ignored.

Verification
REQ-024 Release reset, drw_req=1 write addr 5 data 0xA5A5, no vsync -> drw_gnt=1 same cycle, mem_we=1, mem_addr=5; no display reads.
REQ-025 vsync 0->1, no pops -> FLUSH 1 cycle, then display reads addr 0,1,2,3 on consecutive cycles, disp_empty=0 two cycles after first read, occupancy stops at 4.
REQ-026 FIFO full, drw_req=1 read addr 100 -> drw_gnt=1, drw_rvalid=1 next cycle with RAM word 100; one pop then -> display read addr 4 issued only when drw_req=0 or occupancy<2.
REQ-027 Pop until occupancy 1 with drw_req=1 held -> display wins that cycle, drw_gnt=0; draw granted no later than 2 cycles later.
REQ-028 Display address at 29999 issued -> next display read addr 0; vsync mid-frame -> address restarts at 0, in-flight word discarded.
REQ-029 disp_pop with FIFO empty in RUN -> disp_underrun=1, stays 1 through later vsync, cleared only by reset_n=0.
